// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, ID-stage
// jump/branch resolution and data-memory wait into per-stage controls, plus run lifecycle and stats.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MAX_CYCLES  = 30,
  parameter int unsigned MEM_TIMEOUT = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             load_use_i,
  input  logic             jump_i,
  input  logic             branch_i,
  input  logic             eq_i,
  input  logic             halt_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             pc_we_o,
  output logic             ifid_we_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_en_o,
  output logic             run_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {IDLE, RUN, MEM_WAIT, DONE} state_t;

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [CNT_W-1:0]  cycle_cnt, stall_cnt, flush_cnt;
  logic              err, err_nxt;
  logic              active, take, mwait, rule_flush, rule_stall, at_limit, timeout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign take       = jump_i | (branch_i & eq_i);
  assign mwait      = dmem_req_i & ~dmem_ready_i;
  // start_i low while running leaves the pipeline frozen for the exit cycle
  assign active     = ((state == RUN) || (state == MEM_WAIT)) && start_i;
  assign rule_flush = active && !mwait && take;
  assign rule_stall = active && !mwait && !take && load_use_i;
  // Wide compare: MAX_CYCLES-1 may not fit a narrow saturating counter
  assign at_limit   = (64'(cycle_cnt) == 64'(MAX_CYCLES - 1));
  assign timeout    = mwait && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    pc_we_o       = 1'b0;
    ifid_we_o     = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_en_o     = 1'b0;
    if (active && !mwait) begin
      pipe_en_o = 1'b1;
      if (take) begin
        pc_we_o      = 1'b1;
        ifid_we_o    = 1'b1;
        ifid_flush_o = 1'b1;
      end else if (load_use_i) begin
        idex_bubble_o = 1'b1;
      end else begin
        pc_we_o   = 1'b1;
        ifid_we_o = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = '0;
    err_nxt      = err;
    unique case (state)
      IDLE: if (start_i) state_nxt = RUN;
      RUN, MEM_WAIT: begin
        if (!start_i) begin
          state_nxt = IDLE;
        end else begin
          if (mwait) begin
            wait_cnt_nxt = wait_cnt + 1'b1;
            state_nxt    = MEM_WAIT;
          end else begin
            state_nxt = RUN;
          end
          if (timeout) begin
            err_nxt   = 1'b1;
            state_nxt = DONE;
          end
          if (((state == RUN) && halt_i) || at_limit) state_nxt = DONE;
        end
      end
      DONE: state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      err       <= 1'b0;
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      err      <= err_nxt;
      if (active)     cycle_cnt <= sat_inc(cycle_cnt);
      if (rule_stall) stall_cnt <= sat_inc(stall_cnt);
      if (rule_flush) flush_cnt <= sat_inc(flush_cnt);
    end
  end

  assign run_o       = (state == RUN) || (state == MEM_WAIT);
  assign done_o      = (state == DONE);
  assign err_o       = err;
  assign cycle_cnt_o = cycle_cnt;
  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipelined CPU. Merges the load-use hazard request, taken jump/branch resolution from ID, and a data-memory ready handshake into one set of per-stage write-enable, flush and bubble controls. It also runs a start/run/done lifecycle and keeps saturating cycle, stall and flush counters that benches read hierarchically instead of re-deriving them.

## Interface
- CNT_W, 32, width of each statistics counter
- MAX_CYCLES, 30, RUN/MEM_WAIT cycle budget before automatic DONE
- MEM_TIMEOUT, 8, maximum consecutive MEM_WAIT cycles before error
- clk_i  in  1  clock; all state updates on rising edge
- rst_n_i  in  1  asynchronous active-low reset
- start_i  in  1  level run enable
- load_use_i  in  1  hazard detection unit requests a load-use stall
- jump_i  in  1  jump decoded in ID
- branch_i  in  1  branch decoded in ID
- eq_i  in  1  ID-stage register comparator equal
- halt_i  in  1  halt instruction has reached WB
- dmem_req_i  in  1  MEM stage is issuing a load/store
- dmem_ready_i  in  1  data memory completes access this cycle
- pc_we_o  out  1  PC register write enable
- ifid_we_o  out  1  IF/ID register write enable
- ifid_flush_o  out  1  IF/ID loads a NOP
- idex_bubble_o  out  1  ID/EX control fields forced to zero
- pipe_en_o  out  1  ID/EX, EX/MEM, MEM/WB advance enable
- run_o  out  1  state is RUN or MEM_WAIT
- done_o  out  1  state is DONE
- err_o  out  1  sticky memory-timeout flag
- cycle_cnt_o, stall_cnt_o, flush_cnt_o  out  CNT_W each  statistics counters

## Operation
- States: IDLE, RUN, MEM_WAIT, DONE. Reset enters IDLE. All counters, err_o and the wait counter clear to 0.
- IDLE: all enables and flush/bubble outputs are 0. Go to RUN when start_i=1.
- RUN and MEM_WAIT with start_i=0: go to IDLE. Counters hold. Pipeline contents are untouched.
- `take = jump_i | (branch_i & eq_i)`. `mwait = dmem_req_i & ~dmem_ready_i`.
- Controls in RUN and MEM_WAIT are combinational, evaluated in strict priority:
  1. mwait: every enable is 0, no flush, no bubble. The state is MEM_WAIT while mwait holds.
  2. take: pc_we=1, ifid_we=1, ifid_flush=1, pipe_en=1. load_use_i is ignored.
  3. load_use_i: pc_we=0, ifid_we=0, idex_bubble=1, pipe_en=1.
  4. Otherwise: pc_we, ifid_we and pipe_en are 1. Flush and bubble are 0.
- MEM_WAIT returns to RUN on the edge where dmem_ready_i=1. The wait counter counts consecutive mwait cycles and clears outside MEM_WAIT.
- Timeout: when the wait counter reaches MEM_TIMEOUT, set err_o=1 and go to DONE.
- cycle_cnt increments every RUN or MEM_WAIT cycle.
- stall_cnt increments on rule-3 cycles only. Memory-wait cycles are not counted.
- flush_cnt increments on rule-2 cycles.
- All counters saturate at all-ones.
- Enter DONE on halt_i=1 in RUN, or when cycle_cnt==MAX_CYCLES-1 at an edge in RUN or MEM_WAIT. If both happen together, the result is the same: DONE.
- DONE: all enables 0, done_o=1, counters and err_o hold. Only reset leaves DONE. start_i is ignored.

## Timing
- Control outputs respond in the same cycle as their inputs (zero latency). This lets the stage registers act on the same edge.
- State, counters and err_o update on the rising edge following the qualifying cycle. A counter shows the event one cycle later.
- run_o, done_o and err_o are registered from state.
- Asynchronous reset mid-operation: outputs drop to reset values immediately, without waiting for the clock. Release is synchronous to the next edge.
- Simultaneous take and load_use_i: counts as flush only. stall_cnt is unchanged.
- Simultaneous mwait and take: freeze wins. The flush is re-evaluated after ready.
- start_i dropping during MEM_WAIT: go to IDLE and clear the wait counter.

## Test plan
- Reset then start_i=1 with no hazards for 10 cycles: pc_we/ifid_we/pipe_en=1 throughout. cycle_cnt=10, stall_cnt=0, flush_cnt=0.
- Single-cycle load_use_i pulse: that cycle pc_we=0, ifid_we=0, idex_bubble=1. Next cycle stall_cnt=1. Repeat 3 pulses: stall_cnt=3.
- branch_i=1, eq_i=1, load_use_i=1 same cycle: ifid_flush=1, idex_bubble=0. Then flush_cnt=1, stall_cnt=0. Same with eq_i=0: stall only.
- dmem_req_i=1, dmem_ready_i=0 for 3 cycles then ready: all enables 0 for 3 cycles, run_o=1, cycle_cnt +4, err_o=0. Holding ready low 8 cycles: err_o=1, done_o=1.
- Free run with MAX_CYCLES=30: done_o rises after cycle_cnt=29 edge, cycle_cnt freezes at 30, enables stay 0 despite start_i=1.
- Assert rst_n_i=0 mid-run at cycle 12: counters read 0 and state IDLE before the next edge. Counter saturation checked with CNT_W=4 (cycle_cnt stops at 15 with MAX_CYCLES=40).
